regfile_write_scheduler: RTL and testbench
==========================================

Name: regfile_write_scheduler

Overview:
Sits between the W pipeline register and a single-write-port register file. The block accepts up to two register writes per cycle (E-path and M-path) and queues them in program order in a small FIFO. It retires one write per cycle into the register file and reports which registers still have writes in flight. It also blocks register-file updates once a non-AOK status retires.

Parameters:
DEPTH, 4, FIFO entries; power of two, at least 2
RNONE, 15, register ID meaning "no destination"

Ports:
clock  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high; clears all state
W_valid  input  1  W-stage slot holds a retiring instruction
W_dste  input  4  E-path destination register ID (RNONE = none)
W_vale  input  64  E-path write data
W_dstm  input  4  M-path destination register ID (RNONE = none)
W_valm  input  64  M-path write data
W_status  input  2  instruction status; 0 = AOK, nonzero = halt/fault
W_stall  output  1  W stage must hold; this cycle's W inputs are not accepted
wr_en  output  1  register file write enable
wr_addr  output  4  register file write address (0..14)
wr_data  output  64  register file write data
pending_mask  output  15  bit r set iff at least one queued entry targets register r
count  output  3  current number of FIFO entries (0..DEPTH)
halted  output  1  a non-AOK instruction has retired; sticky until reset

Behaviour:
- Accept condition: accept = W_valid && !W_stall && !halted.
- W_stall = (count == DEPTH), combinational. With one pop per cycle, this guarantees room for two pushes.
- On accept with W_status == 0:
  - Enqueue {W_dste, W_vale} if W_dste != RNONE, then {W_dstm, W_valm} if W_dstm != RNONE.
  - Order is fixed E before M, so when both target the same register the M value lands last and wins.
  - Zero, one or two pushes per cycle.
- On accept with W_status != 0: nothing is enqueued and halted is set next cycle. Entries already queued still drain.
- While halted: W inputs are ignored (no enqueue). W_stall still follows count.
- Drain (combinational from head):
  - wr_en = (count != 0); wr_addr/wr_data = head entry.
  - Head pops on every rising edge where count != 0.
  - wr_addr/wr_data are don't-care when wr_en = 0; drive 0.
- Simultaneous pop and up to two pushes are allowed in the same cycle: count_next = count - pop + pushes.
- Read/write pointers are log2(DEPTH) bits and wrap modulo DEPTH.
- Latency: a write accepted at edge N appears on wr_* during cycle N+1 at the earliest. Later if older entries are ahead.
- pending_mask: combinational OR over valid entries, decoded by address. It reflects current FIFO contents, and the entry being written this cycle still counts. Decode stage uses it for hazard stalls.
- Reset (synchronous, any cycle including mid-drain):
  - count = 0, pointers = 0, halted = 0.
  - wr_en = 0, pending_mask = 0, W_stall = 0.
  - Queued writes are discarded.
- W_valid = 0 means no pushes; drain continues.
- Assertions: wr_addr never equals RNONE when wr_en = 1; count never exceeds DEPTH.

Test Plan:
- Single write: reset, then W_valid=1, dste=3, vale=0xAA, dstm=15, status=0 for one cycle -> next cycle wr_en=1, wr_addr=3, wr_data=0xAA, pending_mask=0x0008; following cycle wr_en=0, count=0.
- Dual write ordering: dste=5/0x11 and dstm=5/0x22 in one cycle -> two consecutive writes, addr 5 data 0x11 then addr 5 data 0x22; pending_mask bit5 set for 2 cycles.
- Backpressure: dual writes (dste=1, dstm=2) every cycle for 6 cycles -> count reaches 4, W_stall=1 in that cycle, and no input is lost. All 12 writes retire in order 1,2,1,2,... at one per cycle.
- Halt: queue 2 entries, then accept status=2 with dste=7 -> reg 7 is never written, halted=1 next cycle. The 2 queued entries still retire. Subsequent W_valid inputs produce no writes.
- Both RNONE: dste=dstm=15, status=0 -> no enqueue, count unchanged, halted=0.
- Reset mid-drain: count=3, assert reset one cycle -> next cycle count=0, wr_en=0, pending_mask=0, halted=0; a new write is accepted normally afterward.

Source files
------------

// File: rtl/regfile_write_scheduler_if.sv
// rtl/regfile_write_scheduler_if.sv - W-stage retirement bus into the register-file write scheduler
interface regfile_write_scheduler_if;
  logic        W_valid;
  logic [3:0]  W_dste;
  logic [63:0] W_vale;
  logic [3:0]  W_dstm;
  logic [63:0] W_valm;
  logic [1:0]  W_status;
  logic        W_stall;

  modport master (
    output W_valid, W_dste, W_vale, W_dstm, W_valm, W_status,
    input  W_stall
  );

  modport slave (
    input  W_valid, W_dste, W_vale, W_dstm, W_valm, W_status,
    output W_stall
  );
endinterface

// File: rtl/regfile_write_scheduler.sv
// rtl/regfile_write_scheduler.sv - program-order FIFO serialising dual W-stage writes onto one register-file port
module regfile_write_scheduler #(
  parameter int          DEPTH = 4,
  parameter logic [3:0]  RNONE = 4'd15,
  localparam int         PW    = $clog2(DEPTH),
  localparam int         CW    = $clog2(DEPTH + 1)
) (
  input  logic                          clock,
  input  logic                          reset,
  regfile_write_scheduler_if.slave      w_if,
  output logic                          wr_en,
  output logic [3:0]                    wr_addr,
  output logic [63:0]                   wr_data,
  output logic [14:0]                   pending_mask,
  output logic [CW-1:0]                 count,
  output logic                          halted
);

  logic [3:0]    addr_q [DEPTH];
  logic [3:0]    addr_d [DEPTH];
  logic [63:0]   data_q [DEPTH];
  logic [63:0]   data_d [DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          halted_q, halted_d;

  logic          accept;
  logic          status_ok;
  logic          push_e;
  logic          push_m;
  logic          pop;
  logic [PW-1:0] wr_ptr_m;
  logic [PW-1:0] entry_off [DEPTH];

  // Offset of each slot from the head; a slot is live when its offset is below count.
  for (genvar i = 0; i < DEPTH; i++) begin : g_off
    assign entry_off[i] = PW'(i) - rd_ptr_q;
  end

  // Handshake: stall only when full, since one pop per cycle leaves room for two pushes.
  always_comb begin
    w_if.W_stall = (count_q == CW'(DEPTH));
    accept       = w_if.W_valid && !w_if.W_stall && !halted_q;
    status_ok    = (w_if.W_status == 2'd0);
    push_e       = accept && status_ok && (w_if.W_dste != RNONE);
    push_m       = accept && status_ok && (w_if.W_dstm != RNONE);
    pop          = (count_q != '0);
    // The M write goes one slot after E only if E was actually pushed.
    wr_ptr_m     = wr_ptr_q + PW'(push_e);
  end

  // Next-state: E lands before M so a same-register M value retires last and wins.
  always_comb begin
    addr_d = addr_q;
    data_d = data_q;
    if (push_e) begin
      addr_d[wr_ptr_q] = w_if.W_dste;
      data_d[wr_ptr_q] = w_if.W_vale;
    end
    if (push_m) begin
      addr_d[wr_ptr_m] = w_if.W_dstm;
      data_d[wr_ptr_m] = w_if.W_valm;
    end
    rd_ptr_d = rd_ptr_q + PW'(pop);
    wr_ptr_d = wr_ptr_q + PW'(push_e) + PW'(push_m);
    count_d  = count_q - CW'(pop) + CW'(push_e) + CW'(push_m);
    halted_d = halted_q | (accept && !status_ok);
  end

  // Control state; reset discards queued writes by zeroing count and pointers.
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      halted_q <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      halted_q <= halted_d;
    end
  end

  // Entry storage needs no reset: contents are only observed through live slots.
  always_ff @(posedge clock) begin
    addr_q <= addr_d;
    data_q <= data_d;
  end

  // Drain port presents the head entry; zero when the queue is empty.
  always_comb begin
    wr_en   = pop;
    wr_addr = pop ? addr_q[rd_ptr_q] : 4'd0;
    wr_data = pop ? data_q[rd_ptr_q] : 64'd0;
  end

  // Hazard mask: OR of decoded addresses over live slots, including the head being retired.
  always_comb begin
    pending_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if ((CW'(entry_off[i]) < count_q) && (addr_q[i] != RNONE)) begin
        pending_mask[addr_q[i]] = 1'b1;
      end
    end
  end

  assign count  = count_q;
  assign halted = halted_q;

  a_no_rnone_write: assert property (@(posedge clock) disable iff (reset)
    !(wr_en && (wr_addr == RNONE)));
  a_count_bound: assert property (@(posedge clock) disable iff (reset)
    count_q <= CW'(DEPTH));

endmodule

// File: tb/tb_regfile_write_scheduler.sv
// tb/tb_regfile_write_scheduler.sv - vector table, backpressure sequence and randomized queue-model check
module tb_regfile_write_scheduler;

  logic        clock = 1'b0;
  logic        reset;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [63:0] wr_data;
  logic [14:0] pending_mask;
  logic [2:0]  count;
  logic        halted;

  int checks = 0;
  int errors = 0;

  regfile_write_scheduler_if w_bus ();

  regfile_write_scheduler #(.DEPTH(4), .RNONE(4'd15)) dut (
    .clock        (clock),
    .reset        (reset),
    .w_if         (w_bus.slave),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .pending_mask (pending_mask),
    .count        (count),
    .halted       (halted)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        rst;
    logic        vld;
    logic [3:0]  de;
    logic [63:0] ve;
    logic [3:0]  dm;
    logic [63:0] vm;
    logic [1:0]  st;
    logic        en;
    logic [3:0]  a;
    logic [63:0] d;
    logic [14:0] pm;
    logic [2:0]  cnt;
    logic        h;
    logic        stl;
  } vec_t;

  typedef struct packed {
    logic [3:0]  a;
    logic [63:0] d;
  } ent_t;

  vec_t tbl[$];
  ent_t mq[$];
  logic mhalt;

  function automatic vec_t mk(input logic rst, input logic vld,
                              input logic [3:0] de, input logic [63:0] ve,
                              input logic [3:0] dm, input logic [63:0] vm,
                              input logic [1:0] st, input logic en,
                              input logic [3:0] a, input logic [63:0] d,
                              input logic [14:0] pm, input logic [2:0] cnt,
                              input logic h);
    vec_t v;
    v.rst = rst; v.vld = vld; v.de = de; v.ve = ve; v.dm = dm; v.vm = vm;
    v.st = st; v.en = en; v.a = a; v.d = d; v.pm = pm; v.cnt = cnt;
    v.h = h; v.stl = 1'b0;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic vld, input logic [3:0] de,
                       input logic [63:0] ve, input logic [3:0] dm,
                       input logic [63:0] vm, input logic [1:0] st);
    reset          = rst;
    w_bus.W_valid  = vld;
    w_bus.W_dste   = de;
    w_bus.W_vale   = ve;
    w_bus.W_dstm   = dm;
    w_bus.W_valm   = vm;
    w_bus.W_status = st;
  endtask

  task automatic check_outs(input string nm, input logic en, input logic [3:0] a,
                            input logic [63:0] d, input logic [14:0] pm,
                            input logic [2:0] cnt, input logic h);
    chk({nm, ".wr_en"},   64'(wr_en),        64'(en));
    chk({nm, ".wr_addr"}, 64'(wr_addr),      64'(a));
    chk({nm, ".wr_data"}, wr_data,           d);
    chk({nm, ".pending"}, 64'(pending_mask), 64'(pm));
    chk({nm, ".count"},   64'(count),        64'(cnt));
    chk({nm, ".halted"},  64'(halted),       64'(h));
  endtask

  initial begin
    int pair;
    int got;
    int maxc;
    logic seen_stall;
    logic acc;

    drive(1'b1, 1'b0, 4'd15, 64'd0, 4'd15, 64'd0, 2'd0);

    //             rst   vld   de     ve        dm     vm        st    en    a      d         pm        cnt   h
    tbl.push_back(mk(1'b1, 1'b0, 4'd15, 64'h0,    4'd15, 64'h0,    2'd0, 1'b0, 4'd0,  64'h0,    15'h0000, 3'd0, 1'b0));
    tbl.push_back(mk(1'b0, 1'b1, 4'd3,  64'hAA,   4'd15, 64'h0,    2'd0, 1'b1, 4'd3,  64'hAA,   15'h0008, 3'd1, 1'b0));
    tbl.push_back(mk(1'b0, 1'b0, 4'd15, 64'h0,    4'd15, 64'h0,    2'd0, 1'b0, 4'd0,  64'h0,    15'h0000, 3'd0, 1'b0));
    tbl.push_back(mk(1'b0, 1'b1, 4'd5,  64'h11,   4'd5,  64'h22,   2'd0, 1'b1, 4'd5,  64'h11,   15'h0020, 3'd2, 1'b0));
    tbl.push_back(mk(1'b0, 1'b0, 4'd15, 64'h0,    4'd15, 64'h0,    2'd0, 1'b1, 4'd5,  64'h22,   15'h0020, 3'd1, 1'b0));
    tbl.push_back(mk(1'b0, 1'b0, 4'd15, 64'h0,    4'd15, 64'h0,    2'd0, 1'b0, 4'd0,  64'h0,    15'h0000, 3'd0, 1'b0));
    tbl.push_back(mk(1'b0, 1'b1, 4'd15, 64'h5,    4'd15, 64'h6,    2'd0, 1'b0, 4'd0,  64'h0,    15'h0000, 3'd0, 1'b0));
    tbl.push_back(mk(1'b0, 1'b1, 4'd1,  64'h101,  4'd2,  64'h202,  2'd0, 1'b1, 4'd1,  64'h101,  15'h0006, 3'd2, 1'b0));
    tbl.push_back(mk(1'b0, 1'b1, 4'd7,  64'h77,   4'd15, 64'h0,    2'd2, 1'b1, 4'd2,  64'h202,  15'h0004, 3'd1, 1'b1));
    tbl.push_back(mk(1'b0, 1'b1, 4'd3,  64'h33,   4'd4,  64'h44,   2'd0, 1'b0, 4'd0,  64'h0,    15'h0000, 3'd0, 1'b1));
    tbl.push_back(mk(1'b0, 1'b0, 4'd15, 64'h0,    4'd15, 64'h0,    2'd0, 1'b0, 4'd0,  64'h0,    15'h0000, 3'd0, 1'b1));
    tbl.push_back(mk(1'b1, 1'b0, 4'd15, 64'h0,    4'd15, 64'h0,    2'd0, 1'b0, 4'd0,  64'h0,    15'h0000, 3'd0, 1'b0));
    tbl.push_back(mk(1'b0, 1'b1, 4'd1,  64'h1,    4'd2,  64'h2,    2'd0, 1'b1, 4'd1,  64'h1,    15'h0006, 3'd2, 1'b0));
    tbl.push_back(mk(1'b0, 1'b1, 4'd3,  64'h3,    4'd4,  64'h4,    2'd0, 1'b1, 4'd2,  64'h2,    15'h001C, 3'd3, 1'b0));
    tbl.push_back(mk(1'b1, 1'b1, 4'd6,  64'h66,   4'd15, 64'h0,    2'd0, 1'b0, 4'd0,  64'h0,    15'h0000, 3'd0, 1'b0));
    tbl.push_back(mk(1'b0, 1'b1, 4'd4,  64'h44,   4'd15, 64'h0,    2'd0, 1'b1, 4'd4,  64'h44,   15'h0010, 3'd1, 1'b0));
    tbl.push_back(mk(1'b0, 1'b0, 4'd15, 64'h0,    4'd15, 64'h0,    2'd0, 1'b0, 4'd0,  64'h0,    15'h0000, 3'd0, 1'b0));
    tbl.push_back(mk(1'b0, 1'b1, 4'd15, 64'h0,    4'd9,  64'h99,   2'd0, 1'b1, 4'd9,  64'h99,   15'h0200, 3'd1, 1'b0));
    tbl.push_back(mk(1'b0, 1'b1, 4'd14, 64'hE,    4'd0,  64'hF0,   2'd0, 1'b1, 4'd14, 64'hE,    15'h4001, 3'd2, 1'b0));
    tbl.push_back(mk(1'b0, 1'b0, 4'd15, 64'h0,    4'd15, 64'h0,    2'd0, 1'b1, 4'd0,  64'hF0,   15'h0001, 3'd1, 1'b0));
    tbl.push_back(mk(1'b0, 1'b0, 4'd15, 64'h0,    4'd15, 64'h0,    2'd0, 1'b0, 4'd0,  64'h0,    15'h0000, 3'd0, 1'b0));

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].rst, tbl[i].vld, tbl[i].de, tbl[i].ve, tbl[i].dm, tbl[i].vm, tbl[i].st);
      @(posedge clock);
      #1;
      check_outs($sformatf("tbl%0d", i), tbl[i].en, tbl[i].a, tbl[i].d,
                 tbl[i].pm, tbl[i].cnt, tbl[i].h);
      chk($sformatf("tbl%0d.W_stall", i), 64'(w_bus.W_stall), 64'(tbl[i].stl));
    end

    // Backpressure: six dual writes held until accepted, twelve in-order retirements.
    drive(1'b1, 1'b0, 4'd15, 64'd0, 4'd15, 64'd0, 2'd0);
    @(posedge clock);
    #1;
    pair = 0;
    got = 0;
    maxc = 0;
    seen_stall = 1'b0;
    for (int cyc = 0; cyc < 60 && got < 12; cyc++) begin
      if (pair < 6)
        drive(1'b0, 1'b1, 4'd1, 64'(pair * 2), 4'd2, 64'(pair * 2 + 1), 2'd0);
      else
        drive(1'b0, 1'b0, 4'd15, 64'd0, 4'd15, 64'd0, 2'd0);
      acc = (pair < 6) && !w_bus.W_stall;
      if (w_bus.W_stall) begin
        seen_stall = 1'b1;
        chk("bp.stall_count", 64'(count), 64'd4);
      end
      @(posedge clock);
      #1;
      if (acc) pair++;
      if (int'(count) > maxc) maxc = int'(count);
      if (wr_en) begin
        chk($sformatf("bp.addr%0d", got), 64'(wr_addr), (got % 2 == 0) ? 64'd1 : 64'd2);
        chk($sformatf("bp.data%0d", got), wr_data, 64'(got));
        got++;
      end
    end
    chk("bp.retired", 64'(got), 64'd12);
    chk("bp.max_count", 64'(maxc), 64'd4);
    chk("bp.stall_seen", 64'(seen_stall), 64'd1);
    @(posedge clock);
    #1;
    chk("bp.empty_after", 64'(count), 64'd0);

    // Randomized run against a queue model of program-order retirement.
    drive(1'b1, 1'b0, 4'd15, 64'd0, 4'd15, 64'd0, 2'd0);
    @(posedge clock);
    #1;
    mq.delete();
    mhalt = 1'b0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      logic        r_rst;
      logic        r_vld;
      logic [3:0]  r_de;
      logic [3:0]  r_dm;
      logic [63:0] r_ve;
      logic [63:0] r_vm;
      logic [1:0]  r_st;
      logic [14:0] pm;
      ent_t        e;

      r_rst = ($urandom_range(0, 59) == 0);
      r_vld = ($urandom_range(0, 3) != 0);
      r_de  = ($urandom_range(0, 2) == 0) ? 4'd15 : 4'($urandom_range(0, 14));
      r_dm  = ($urandom_range(0, 2) == 0) ? 4'd15 : 4'($urandom_range(0, 14));
      r_ve  = {$urandom, $urandom};
      r_vm  = {$urandom, $urandom};
      r_st  = ($urandom_range(0, 39) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
      drive(r_rst, r_vld, r_de, r_ve, r_dm, r_vm, r_st);

      chk($sformatf("rnd%0d.W_stall", cyc), 64'(w_bus.W_stall), 64'(mq.size() == 4));
      acc = r_vld && (mq.size() != 4) && !mhalt;

      @(posedge clock);
      #1;

      if (r_rst) begin
        mq.delete();
        mhalt = 1'b0;
      end else begin
        if (mq.size() != 0) void'(mq.pop_front());
        if (acc) begin
          if (r_st != 2'd0) begin
            mhalt = 1'b1;
          end else begin
            if (r_de != 4'd15) begin e.a = r_de; e.d = r_ve; mq.push_back(e); end
            if (r_dm != 4'd15) begin e.a = r_dm; e.d = r_vm; mq.push_back(e); end
          end
        end
      end

      pm = '0;
      foreach (mq[k]) pm[mq[k].a] = 1'b1;
      if (mq.size() != 0)
        check_outs($sformatf("rnd%0d", cyc), 1'b1, mq[0].a, mq[0].d, pm, 3'(mq.size()), mhalt);
      else
        check_outs($sformatf("rnd%0d", cyc), 1'b0, 4'd0, 64'd0, pm, 3'd0, mhalt);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
